ksa_pipe: RTL and testbench

- Parametrised, pipelined Kogge-Stone adder/subtractor for conv2d partial-sum paths.
- Full log2 parallel-prefix carry tree with configurable register insertion.
- Valid/ready handshake with backpressure, carry-in, add/sub mode, and carry-out and signed-overflow flags.
- Sits between multiplier outputs and the accumulator/line-buffer write path.

---
 rtl/ksa_pkg.sv | 46 ++++
 rtl/ksa_prefix_level.sv | 23 ++
 rtl/ksa_pipe.sv | 192 +++++++++++++++++++
 tb/tb_ksa_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder/subtractor.
// Optional saturation is enabled by defining KSA_PIPE_SAT_EN.
package ksa_pkg;

    localparam int KSA_MAX_WIDTH = 64;

    // Ceiling log2, valid for n >= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // True when a register bank follows prefix level 'level'.
    function automatic bit ksa_reg_after_level(
        input int level,
        input int levels,
        input int s
    );
        bit hit;
        hit = 1'b0;
        for (int i = 1; i < s; i++) begin
            if ((i * levels + s - 1) / s - 1 == level) hit = 1'b1;
        end
        return hit;
    endfunction

    // Number of register banks placed before 'level'; this is the
    // pipeline stage index of the bank after 'level', if any.
    function automatic int ksa_regs_before(
        input int level,
        input int levels,
        input int s
    );
        int cnt;
        cnt = 0;
        for (int l = 0; l < level; l++) begin
            if (ksa_reg_after_level(l, levels, s)) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One combinational Kogge-Stone prefix level combining span SPAN.
// Bits below SPAN pass through unchanged.
module ksa_prefix_level #(
    parameter int WIDTH = 32,
    parameter int SPAN  = 1
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_in,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] g_out
);

    // Merge each bit's group with the group SPAN positions below it.
    always_comb begin
        p_out = p_in;
        g_out = g_in;
        for (int i = SPAN; i < WIDTH; i++) begin
            g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
            p_out[i] = p_in[i] & p_in[i-SPAN];
        end
    end

endmodule

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Define KSA_PIPE_SAT_EN to saturate the result on signed overflow.
module ksa_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int S      = PIPE_STAGES;

    logic [S-1:0] vld;
    logic [S-1:0] ld;
    logic [S:0]   src;

    assign src       = {vld, in_valid};
    assign in_ready  = ld[0];
    assign out_valid = vld[S-1];

    // A stage loads if it or any later stage is empty, or output drains.
    always_comb begin
        ld = '0;
        for (int n = 0; n < S; n++) begin
            ld[n] = out_ready;
            for (int m = n; m < S; m++) begin
                if (!vld[m]) ld[n] = 1'b1;
            end
        end
    end

    // Stage valid bits; reset drops every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            for (int n = 0; n < S; n++) begin
                if (ld[n]) vld[n] <= src[n];
            end
        end
    end

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_init;
    logic [WIDTH-1:0] g_init;
    logic             c0;

    assign b_eff  = in_sub ? ~in_b : in_b;
    assign c0     = in_sub ? 1'b1 : in_cin;
    assign p_init = in_a ^ b_eff;

    // Generate terms with the carry-in folded into bit 0.
    always_comb begin
        g_init    = in_a & b_eff;
        g_init[0] = g_init[0] | (p_init[0] & c0);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : lvl
        localparam bit REG = ksa_reg_after_level(k, LEVELS, S);
        localparam int ST  = ksa_regs_before(k, LEVELS, S);

        logic [WIDTH-1:0] ip, ig, ir;
        logic [WIDTH-1:0] np, ng;
        logic [WIDTH-1:0] qp, qg, qr;
        logic             ic, qc;
        logic             ia, qa;
        logic [TAG_W-1:0] it, qt;

        if (k == 0) begin : head
            assign ip = p_init;
            assign ig = g_init;
            assign ir = p_init;
            assign ic = c0;
            assign ia = in_a[WIDTH-1];
            assign it = in_tag;
        end else begin : link
            assign ip = lvl[k-1].qp;
            assign ig = lvl[k-1].qg;
            assign ir = lvl[k-1].qr;
            assign ic = lvl[k-1].qc;
            assign ia = lvl[k-1].qa;
            assign it = lvl[k-1].qt;
        end

        ksa_prefix_level #(
            .WIDTH (WIDTH),
            .SPAN  (1 << k)
        ) u_level (
            .p_in  (ip),
            .g_in  (ig),
            .p_out (np),
            .g_out (ng)
        );

        if (REG) begin : rg
            // Mid-tree pipeline bank for stage ST.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qp <= '0;
                    qg <= '0;
                    qr <= '0;
                    qc <= 1'b0;
                    qa <= 1'b0;
                    qt <= '0;
                end else if (ld[ST]) begin
                    qp <= np;
                    qg <= ng;
                    qr <= ir;
                    qc <= ic;
                    qa <= ia;
                    qt <= it;
                end
            end
        end else begin : cb
            assign qp = np;
            assign qg = ng;
            assign qr = ir;
            assign qc = ic;
            assign qa = ia;
            assign qt = it;
        end
    end

    logic [WIDTH-1:0] fg;
    logic [WIDTH-1:0] fr;
    logic             fc;
    logic             fa;
    logic [TAG_W-1:0] ft;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] sum_d;
    logic             cout_w;
    logic             ovf_w;
    logic             unused_tail;

    assign fg = lvl[LEVELS-1].qg;
    assign fr = lvl[LEVELS-1].qr;
    assign fc = lvl[LEVELS-1].qc;
    assign fa = lvl[LEVELS-1].qa;
    assign ft = lvl[LEVELS-1].qt;

    assign sum_w  = fr ^ {fg[WIDTH-2:0], fc};
    assign cout_w = fg[WIDTH-1];
    assign ovf_w  = fg[WIDTH-1] ^ fg[WIDTH-2];

`ifdef KSA_PIPE_SAT_EN
    // Clamp toward the sign of operand A on signed overflow.
    always_comb begin
        sum_d = sum_w;
        if (ovf_w) begin
            sum_d = fa ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
    assign unused_tail = ^lvl[LEVELS-1].qp;
`else
    assign sum_d       = sum_w;
    assign unused_tail = ^{lvl[LEVELS-1].qp, fa};
`endif

    // Output register; holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
            out_tag  <= '0;
        end else if (ld[S-1]) begin
            out_sum  <= sum_d;
            out_cout <= cout_w;
            out_ovf  <= ovf_w;
            out_tag  <= ft;
        end
    end

endmodule

// File: tb/tb_ksa_pipe.sv
// Self-checking bench for ksa_pipe: directed cases, backpressure and
// randomized traffic scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ksa_pipe;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_cin = 1'b0;
    logic          in_sub = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    ksa_pipe #(
        .WIDTH       (W),
        .PIPE_STAGES (S),
        .TAG_W       (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_recv = 0;

    task automatic check(input string name,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic cin,
                                   input logic sub,
                                   input logic [TW-1:0] tag);
        exp_t        e;
        logic [63:0] u;
        longint      sa, sb, s, maxp, minn;
        sa   = $signed(a);
        sb   = $signed(b);
        maxp = (longint'(1) << (W - 1)) - 1;
        minn = -(longint'(1) << (W - 1));
        if (sub) begin
            u      = 64'(a) - 64'(b);
            e.cout = (a >= b);
            s      = sa - sb;
        end else begin
            u      = 64'(a) + 64'(b) + 64'(cin);
            e.cout = u[W];
            s      = sa + sb + longint'(cin);
        end
        e.sum = u[W-1:0];
        e.ovf = (s > maxp) || (s < minn);
        e.tag = tag;
`ifdef KSA_PIPE_SAT_EN
        if (e.ovf) begin
            e.sum        = '0;
            e.sum[W-1]   = a[W-1];
            if (!a[W-1]) e.sum = ~e.sum;
        end
`endif
        return e;
    endfunction

    logic          hold_v = 1'b0;
    logic [W-1:0]  hold_sum;
    logic          hold_cout;
    logic          hold_ovf;
    logic [TW-1:0] hold_tag;

    // Output monitor: scoreboard on handshake, stability while stalled.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_sum", 64'(out_sum), 64'(hold_sum));
                check("stall_flags", 64'({out_cout, out_ovf}),
                      64'({hold_cout, hold_ovf}));
                check("stall_tag", 64'(out_tag), 64'(hold_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    n_recv++;
                    check("sum", 64'(out_sum), 64'(e.sum));
                    check("cout", 64'(out_cout), 64'(e.cout));
                    check("ovf", 64'(out_ovf), 64'(e.ovf));
                    check("tag", 64'(out_tag), 64'(e.tag));
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_sum  = out_sum;
            hold_cout = out_cout;
            hold_ovf  = out_ovf;
            hold_tag  = out_tag;
        end
    end

    task automatic send(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic cin,
                        input logic sub,
                        input logic [TW-1:0] tag,
                        input exp_t e);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_tag   = tag;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        else q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0]  a, b;
        logic          cin, sub;
        logic [TW-1:0] tag;
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
        tag = TW'($urandom);
        case ($urandom_range(0, 7))
            0: a = {1'b0, {(W-1){1'b1}}};
            1: a = {1'b1, {(W-1){1'b0}}};
            2: b = '1;
            3: b = a;
            default: ;
        endcase
        send(a, b, cin, sub, tag, model(a, b, cin, sub, tag));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int   n;
        int   base;
        bit   done;
        exp_t e;

        // Reset values while held in reset.
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_cout", 64'(out_cout), 64'd0);
        check("rst_ovf", 64'(out_ovf), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency of a single beat.
        e = '{sum: 32'h9, cout: 1'b0, ovf: 1'b0, tag: 4'hA};
        send(32'h5, 32'h3, 1'b1, 1'b0, 4'hA, e);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(n), 64'(S));
        drain();

        // Asynchronous reset while a beat is in flight.
        base = n_recv;
        e = '{sum: 32'h3, cout: 1'b0, ovf: 1'b0, tag: 4'h3};
        send(32'h1, 32'h2, 1'b0, 1'b0, 4'h3, e);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        check("midrst_lost", 64'(n_recv - base), 64'd0);

        // Directed arithmetic corners.
        e = '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, tag: 4'h1};
        send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'h1, e);
`ifdef KSA_PIPE_SAT_EN
        e = '{sum: 32'h7FFF_FFFF, cout: 1'b0, ovf: 1'b1, tag: 4'h2};
`else
        e = '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, tag: 4'h2};
`endif
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h2, e);
        e = '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, tag: 4'h4};
        send(32'h3, 32'h5, 1'b1, 1'b1, 4'h4, e);
        e = '{sum: 32'h2, cout: 1'b1, ovf: 1'b0, tag: 4'h5};
        send(32'h5, 32'h3, 1'b1, 1'b1, 4'h5, e);
        drain();

        // Back-to-back beats with a four-cycle downstream stall.
        base = n_recv;
        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
            end
            begin
                out_ready = 1'b1;
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                check("bp_in_ready", 64'(in_ready), 64'd0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_recv - base), 64'd10);

        // Random traffic with random backpressure.
        base = n_recv;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2000; i++) send_rand();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", 64'(n_recv - base), 64'd2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
